// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access stage: funct3 access codes,
// FSM state encoding and the access-size decode helper.
package mem_stage_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } mem_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } acc_size_e;

   // Reserved funct3 codes fall back to a word access.
   function automatic acc_size_e f3_size(input logic [2:0] f3);
      acc_size_e sz;
      case (f3)
         F3_LB, F3_LBU: sz = SZ_B;
         F3_LH, F3_LHU: sz = SZ_H;
         default:       sz = SZ_W;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for the data bus: byte enables, store replication,
// misalignment detection and load extraction/extension.
module lsu_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [31:0] ld_raw,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic        misalign,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic        sgn;

   always_comb begin
      ld_b     = ld_raw[{addr_lo, 3'b000} +: 8];
      ld_h     = ld_raw[{addr_lo[1], 4'b0000} +: 16];
      sgn      = ~funct3[2];
      be       = 4'b1111;
      wdata    = st_data;
      misalign = 1'b0;
      ld_data  = ld_raw;
      unique case (f3_size(funct3))
         SZ_B: begin
            be      = 4'b0001 << addr_lo;
            wdata   = {4{st_data[7:0]}};
            ld_data = {{24{sgn & ld_b[7]}}, ld_b};
         end
         SZ_H: begin
            be       = 4'b0011 << addr_lo;
            wdata    = {2{st_data[15:0]}};
            misalign = addr_lo[0];
            ld_data  = {{16{sgn & ld_h[15]}}, ld_h};
         end
         default: begin
            misalign = |addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the req/gnt data bus for loads and stores,
// holds the MEM/WB register and stalls the front end while a bus op is open.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int RADDR_W = 5,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ex_mem_valid_i,
   input  logic [RADDR_W-1:0] ex_mem_reg_w_addr_i,
   input  logic               ex_mem_reg_w_ena_i,
   input  logic [XLEN-1:0]    ex_mem_reg_w_data_i,
   input  logic               ex_mem_mem_r_ena_i,
   input  logic               ex_mem_mem_w_ena_i,
   input  logic [XLEN-1:0]    ex_mem_mem_w_data_i,
   input  logic [2:0]         ex_mem_funct3_i,
   output logic               dmem_req_o,
   output logic               dmem_we_o,
   output logic [XLEN-1:0]    dmem_addr_o,
   output logic [XLEN-1:0]    dmem_wdata_o,
   output logic [3:0]         dmem_be_o,
   input  logic               dmem_gnt_i,
   input  logic               dmem_rvalid_i,
   input  logic [XLEN-1:0]    dmem_rdata_i,
   output logic [RADDR_W-1:0] mem_wb_reg_w_addr_o,
   output logic               mem_wb_reg_w_ena_o,
   output logic [XLEN-1:0]    mem_wb_reg_w_data_o,
   output logic               mem_hold_o,
   output logic               misalign_o,
   output logic               bus_err_o
);

   localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

   mem_state_e         state, state_n;
   logic [7:0]         cnt, cnt_n;
   logic               mem_op, is_st, timeout, mis;
   logic               req, hold, mis_p, berr;
   logic               wb_ld, wb_ena_n;
   logic [XLEN-1:0]    wb_data_n;
   logic [XLEN-1:0]    ld_data;
   logic [RADDR_W-1:0] wb_addr_q;
   logic               wb_ena_q;
   logic [XLEN-1:0]    wb_data_q;

   lsu_align u_align (
      .funct3   (ex_mem_funct3_i),
      .addr_lo  (ex_mem_reg_w_data_i[1:0]),
      .st_data  (ex_mem_mem_w_data_i),
      .ld_raw   (dmem_rdata_i),
      .be       (dmem_be_o),
      .wdata    (dmem_wdata_o),
      .misalign (mis),
      .ld_data  (ld_data)
   );

   assign mem_op  = ex_mem_valid_i & (ex_mem_mem_r_ena_i | ex_mem_mem_w_ena_i);
   assign is_st   = ex_mem_mem_w_ena_i;
   assign timeout = (cnt == TO_CNT);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      req       = 1'b0;
      hold      = 1'b0;
      mis_p     = 1'b0;
      berr      = 1'b0;
      wb_ld     = 1'b1;
      wb_ena_n  = 1'b0;
      wb_data_n = ex_mem_reg_w_data_i;
      unique case (state)
         S_IDLE: begin
            cnt_n    = 8'd0;
            wb_ena_n = ex_mem_valid_i & ex_mem_reg_w_ena_i & ~mem_op;
            if (mem_op && mis) begin
               mis_p = 1'b1;
            end else if (mem_op) begin
               req = 1'b1;
               if (!dmem_gnt_i) begin
                  state_n = S_REQ;
                  hold    = 1'b1;
               end else if (!is_st) begin
                  state_n = S_WAIT;
                  hold    = 1'b1;
               end
            end
         end
         S_REQ: begin
            if (timeout) begin
               berr    = 1'b1;
               state_n = S_IDLE;
            end else begin
               req = 1'b1;
               if (dmem_gnt_i) begin
                  cnt_n = 8'd0;
                  if (is_st) begin
                     state_n = S_IDLE;
                  end else begin
                     state_n = S_WAIT;
                     hold    = 1'b1;
                  end
               end else begin
                  cnt_n = cnt + 8'd1;
                  hold  = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (timeout) begin
               berr    = 1'b1;
               state_n = S_IDLE;
            end else if (dmem_rvalid_i) begin
               state_n   = S_IDLE;
               wb_ena_n  = ex_mem_reg_w_ena_i;
               wb_data_n = ld_data;
            end else begin
               cnt_n = cnt + 8'd1;
               hold  = 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
      // A held instruction must not overwrite what forwarding already sees.
      if (hold) wb_ld = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 8'd0;
         wb_addr_q <= '0;
         wb_ena_q  <= 1'b0;
         wb_data_q <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (wb_ld) begin
            wb_addr_q <= ex_mem_reg_w_addr_i;
            wb_ena_q  <= wb_ena_n;
            wb_data_q <= wb_data_n;
         end
      end
   end

   // Bus controls drop the moment reset rises, even with a live EX/MEM op.
   assign dmem_req_o  = req & ~rst;
   assign dmem_we_o   = req & is_st & ~rst;
   assign dmem_addr_o = {ex_mem_reg_w_data_i[XLEN-1:2], 2'b00};
   assign mem_hold_o  = hold & ~rst;
   assign misalign_o  = mis_p & ~rst;
   assign bus_err_o   = berr & ~rst;

   assign mem_wb_reg_w_addr_o = wb_addr_q;
   assign mem_wb_reg_w_ena_o  = wb_ena_q;
   assign mem_wb_reg_w_data_o = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: transaction-level expectations with a
// per-cycle compare process and literal checks on key results.
module tb_mem_stage;

   localparam int TO = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_mem_valid_i;
   logic [4:0]  ex_mem_reg_w_addr_i;
   logic        ex_mem_reg_w_ena_i;
   logic [31:0] ex_mem_reg_w_data_i;
   logic        ex_mem_mem_r_ena_i;
   logic        ex_mem_mem_w_ena_i;
   logic [31:0] ex_mem_mem_w_data_i;
   logic [2:0]  ex_mem_funct3_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic [4:0]  mem_wb_reg_w_addr_o;
   logic        mem_wb_reg_w_ena_o;
   logic [31:0] mem_wb_reg_w_data_o;
   logic        mem_hold_o;
   logic        misalign_o;
   logic        bus_err_o;

   mem_stage dut (
      .clk                 (clk),
      .rst                 (rst),
      .ex_mem_valid_i      (ex_mem_valid_i),
      .ex_mem_reg_w_addr_i (ex_mem_reg_w_addr_i),
      .ex_mem_reg_w_ena_i  (ex_mem_reg_w_ena_i),
      .ex_mem_reg_w_data_i (ex_mem_reg_w_data_i),
      .ex_mem_mem_r_ena_i  (ex_mem_mem_r_ena_i),
      .ex_mem_mem_w_ena_i  (ex_mem_mem_w_ena_i),
      .ex_mem_mem_w_data_i (ex_mem_mem_w_data_i),
      .ex_mem_funct3_i     (ex_mem_funct3_i),
      .dmem_req_o          (dmem_req_o),
      .dmem_we_o           (dmem_we_o),
      .dmem_addr_o         (dmem_addr_o),
      .dmem_wdata_o        (dmem_wdata_o),
      .dmem_be_o           (dmem_be_o),
      .dmem_gnt_i          (dmem_gnt_i),
      .dmem_rvalid_i       (dmem_rvalid_i),
      .dmem_rdata_i        (dmem_rdata_i),
      .mem_wb_reg_w_addr_o (mem_wb_reg_w_addr_o),
      .mem_wb_reg_w_ena_o  (mem_wb_reg_w_ena_o),
      .mem_wb_reg_w_data_o (mem_wb_reg_w_data_o),
      .mem_hold_o          (mem_hold_o),
      .misalign_o          (misalign_o),
      .bus_err_o           (bus_err_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   logic        exp_req, exp_we, exp_hold, exp_mis, exp_berr;
   logic [31:0] exp_addr, exp_wd;
   logic [3:0]  exp_be;
   logic        exp_wb_ena;
   logic [4:0]  exp_wb_addr;
   logic [31:0] exp_wb_data;
   bit          nxt_ld;
   logic        nxt_ena;
   logic [4:0]  nxt_addr;
   logic [31:0] nxt_data;

   int          obs_req, obs_hold, obs_mis, obs_berr;
   logic [3:0]  last_be;
   logic [31:0] last_wd;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   function automatic int m_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit m_aligned(input logic [2:0] f3, input logic [31:0] a);
      return (a % m_size(f3)) == 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int v;
      v = ((1 << m_size(f3)) - 1) << (a % 4);
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] r;
      int n;
      n = m_size(f3);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] raw);
      logic [31:0] v, mask;
      int n;
      n = m_size(f3);
      if (n == 4) return raw;
      v    = raw >> (8 * (a % 4));
      mask = (32'd1 << (8 * n)) - 32'd1;
      v    = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         chk("req", {31'd0, dmem_req_o}, {31'd0, exp_req});
         chk("we", {31'd0, dmem_we_o}, {31'd0, exp_we});
         chk("hold", {31'd0, mem_hold_o}, {31'd0, exp_hold});
         chk("misalign", {31'd0, misalign_o}, {31'd0, exp_mis});
         chk("bus_err", {31'd0, bus_err_o}, {31'd0, exp_berr});
         chk("wb_ena", {31'd0, mem_wb_reg_w_ena_o}, {31'd0, exp_wb_ena});
         if (exp_req) begin
            chk("addr", dmem_addr_o, exp_addr);
            chk("be", {28'd0, dmem_be_o}, {28'd0, exp_be});
            chk("wdata", dmem_wdata_o, exp_wd);
         end
         if (exp_wb_ena) begin
            chk("wb_addr", {27'd0, mem_wb_reg_w_addr_o}, {27'd0, exp_wb_addr});
            chk("wb_data", mem_wb_reg_w_data_o, exp_wb_data);
         end
      end
   end

   task automatic clr_exp();
      exp_req = 0; exp_we = 0; exp_hold = 0; exp_mis = 0; exp_berr = 0;
      exp_addr = 0; exp_be = 0; exp_wd = 0;
   endtask

   task automatic tick();
      @(negedge clk);
      obs_req  += int'(dmem_req_o);
      obs_hold += int'(mem_hold_o);
      obs_mis  += int'(misalign_o);
      obs_berr += int'(bus_err_o);
      if (dmem_req_o) begin
         last_be = dmem_be_o;
         last_wd = dmem_wdata_o;
      end
      @(posedge clk);
      #1;
      clr_exp();
      dmem_gnt_i    = 0;
      dmem_rvalid_i = 0;
      if (nxt_ld) begin
         exp_wb_ena  = nxt_ena;
         exp_wb_addr = nxt_addr;
         exp_wb_data = nxt_data;
      end
      nxt_ld = 0;
   endtask

   // gd: request cycles before gnt; rvd: cycles after gnt until rvalid.
   task automatic run_op(input bit v, input bit rd_r, input bit wr,
                         input logic [4:0] rd, input bit rd_en,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [2:0] f3, input int gd, input int rvd,
                         input logic [31:0] raw, input bit spur,
                         input bit rst_wait);
      obs_req = 0; obs_hold = 0; obs_mis = 0; obs_berr = 0;
      last_be = 0; last_wd = 0;
      ex_mem_valid_i      = v;
      ex_mem_mem_r_ena_i  = rd_r;
      ex_mem_mem_w_ena_i  = wr;
      ex_mem_reg_w_addr_i = rd;
      ex_mem_reg_w_ena_i  = rd_en;
      ex_mem_reg_w_data_i = alu;
      ex_mem_mem_w_data_i = sd;
      ex_mem_funct3_i     = f3;
      if (!(v && (rd_r || wr))) begin
         nxt_ld = 1; nxt_ena = v & rd_en; nxt_addr = rd; nxt_data = alu;
         tick();
         return;
      end
      if (!m_aligned(f3, alu)) begin
         exp_mis = 1;
         nxt_ld = 1; nxt_ena = 0; nxt_addr = rd; nxt_data = alu;
         tick();
         return;
      end
      for (int k = 0; k <= TO + 1; k++) begin
         if (k == TO + 1) begin
            exp_berr = 1;
            nxt_ld = 1; nxt_ena = 0; nxt_addr = rd; nxt_data = alu;
            tick();
            return;
         end
         exp_req  = 1;
         exp_we   = wr;
         exp_addr = alu & 32'hFFFF_FFFC;
         exp_be   = m_be(f3, alu);
         exp_wd   = m_wdata(f3, sd);
         dmem_gnt_i = (k == gd);
         exp_hold = !(k == gd && wr);
         if (k == gd) begin
            if (spur) begin
               dmem_rvalid_i = 1;
               dmem_rdata_i  = 32'hFFFF_FFFF;
            end
            if (wr) begin
               nxt_ld = 1; nxt_ena = 0; nxt_addr = rd; nxt_data = alu;
            end
            tick();
            break;
         end
         tick();
      end
      if (wr) return;
      for (int j = 1; j <= TO + 1; j++) begin
         if (rst_wait) begin
            chk_on = 0;
            rst = 1;
            #1;
            chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
            chk("rst_hold", {31'd0, mem_hold_o}, 32'd0);
            chk("rst_wb_ena", {31'd0, mem_wb_reg_w_ena_o}, 32'd0);
            chk("rst_wb_data", mem_wb_reg_w_data_o, 32'd0);
            chk("rst_wb_addr", {27'd0, mem_wb_reg_w_addr_o}, 32'd0);
            ex_mem_valid_i = 0; ex_mem_mem_r_ena_i = 0; ex_mem_mem_w_ena_i = 0;
            ex_mem_reg_w_addr_i = 0; ex_mem_reg_w_ena_i = 0;
            ex_mem_reg_w_data_i = 0; ex_mem_mem_w_data_i = 0;
            dmem_rvalid_i = 1;
            dmem_rdata_i  = 32'h1357_9BDF;
            @(posedge clk);
            #1;
            rst = 0;
            clr_exp();
            exp_wb_ena = 0; exp_wb_addr = 0; exp_wb_data = 0;
            dmem_rvalid_i = 1;
            chk_on = 1;
            nxt_ld = 1; nxt_ena = 0; nxt_addr = 0; nxt_data = 0;
            tick();
            return;
         end
         if (j == TO + 1) begin
            exp_berr = 1;
            nxt_ld = 1; nxt_ena = 0; nxt_addr = rd; nxt_data = alu;
            tick();
            return;
         end
         dmem_rvalid_i = (j == rvd);
         dmem_rdata_i  = raw;
         exp_hold = (j != rvd);
         if (j == rvd) begin
            nxt_ld = 1; nxt_ena = rd_en; nxt_addr = rd;
            nxt_data = m_load(f3, alu, raw);
            tick();
            return;
         end
         tick();
      end
   endtask

   task automatic bubble();
      run_op(0, 0, 0, 5'd0, 0, 32'd0, 32'd0, 3'b000, 0, 1, 32'd0, 0, 0);
   endtask

   initial begin
      rst = 1;
      ex_mem_valid_i = 0; ex_mem_reg_w_addr_i = 0; ex_mem_reg_w_ena_i = 0;
      ex_mem_reg_w_data_i = 0; ex_mem_mem_r_ena_i = 0; ex_mem_mem_w_ena_i = 0;
      ex_mem_mem_w_data_i = 0; ex_mem_funct3_i = 0;
      dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
      clr_exp();
      exp_wb_ena = 0; exp_wb_addr = 0; exp_wb_data = 0;
      nxt_ld = 0;
      @(negedge clk);
      chk("reset_req", {31'd0, dmem_req_o}, 32'd0);
      chk("reset_we", {31'd0, dmem_we_o}, 32'd0);
      chk("reset_hold", {31'd0, mem_hold_o}, 32'd0);
      chk("reset_mis", {31'd0, misalign_o}, 32'd0);
      chk("reset_berr", {31'd0, bus_err_o}, 32'd0);
      chk("reset_wb_ena", {31'd0, mem_wb_reg_w_ena_o}, 32'd0);
      chk("reset_wb_addr", {27'd0, mem_wb_reg_w_addr_o}, 32'd0);
      chk("reset_wb_data", mem_wb_reg_w_data_o, 32'd0);
      @(posedge clk);
      #1;
      rst = 0;
      chk_on = 1;

      // ADD x5 <- 0x1234
      run_op(1, 0, 0, 5'd5, 1, 32'h0000_1234, 32'd0, 3'b000, 0, 1, 32'd0, 0, 0);
      chk("add_data", mem_wb_reg_w_data_o, 32'h0000_1234);
      chk("add_addr", {27'd0, mem_wb_reg_w_addr_o}, 32'd5);
      chk("add_hold", obs_hold, 0);

      // LW 0x100, gnt same cycle, rvalid next
      run_op(1, 1, 0, 5'd7, 1, 32'h100, 32'd0, 3'b010, 0, 1, 32'hDEAD_BEEF, 0, 0);
      chk("lw_data", mem_wb_reg_w_data_o, 32'hDEAD_BEEF);
      chk("lw_hold", obs_hold, 1);

      // LB / LBU at 0x103
      run_op(1, 1, 0, 5'd8, 1, 32'h103, 32'd0, 3'b000, 0, 2, 32'h8012_3456, 0, 0);
      chk("lb_data", mem_wb_reg_w_data_o, 32'hFFFF_FF80);
      run_op(1, 1, 0, 5'd9, 1, 32'h103, 32'd0, 3'b100, 0, 1, 32'h8012_3456, 0, 0);
      chk("lbu_data", mem_wb_reg_w_data_o, 32'h0000_0080);

      // SH 0x202 with gnt 3 cycles late
      run_op(1, 0, 1, 5'd0, 0, 32'h202, 32'h0000_ABCD, 3'b001, 3, 1, 32'd0, 0, 0);
      chk("sh_req_cycles", obs_req, 4);
      chk("sh_hold_cycles", obs_hold, 3);
      chk("sh_be", {28'd0, last_be}, 32'h0000_000C);
      chk("sh_wdata", last_wd, 32'hABCD_ABCD);
      chk("sh_wb_ena", {31'd0, mem_wb_reg_w_ena_o}, 32'd0);

      // Misaligned LW
      run_op(1, 1, 0, 5'd3, 1, 32'h101, 32'd0, 3'b010, 0, 1, 32'd0, 0, 0);
      chk("mis_pulse", obs_mis, 1);
      chk("mis_req", obs_req, 0);
      chk("mis_wb_ena", {31'd0, mem_wb_reg_w_ena_o}, 32'd0);

      // Assorted sizes, x0 destination, spurious rvalid in gnt cycle
      run_op(1, 1, 0, 5'd4, 1, 32'h102, 32'd0, 3'b001, 1, 1, 32'h8001_1111, 0, 0);
      chk("lh_data", mem_wb_reg_w_data_o, 32'hFFFF_8001);
      run_op(1, 1, 0, 5'd6, 1, 32'h100, 32'd0, 3'b101, 0, 3, 32'h1234_ABCD, 0, 0);
      chk("lhu_data", mem_wb_reg_w_data_o, 32'h0000_ABCD);
      run_op(1, 0, 1, 5'd0, 0, 32'h300, 32'hCAFE_F00D, 3'b010, 0, 1, 32'd0, 0, 0);
      run_op(1, 0, 1, 5'd0, 0, 32'h301, 32'h0000_005A, 3'b000, 1, 1, 32'd0, 0, 0);
      chk("sb_wdata", last_wd, 32'h5A5A_5A5A);
      run_op(1, 1, 0, 5'd0, 1, 32'h104, 32'd0, 3'b010, 0, 1, 32'h0BAD_CAFE, 0, 0);
      chk("x0_wb_ena", {31'd0, mem_wb_reg_w_ena_o}, 32'd1);
      run_op(1, 1, 0, 5'd11, 1, 32'h108, 32'd0, 3'b010, 1, 2, 32'h600D_D00D, 1, 0);
      chk("spur_data", mem_wb_reg_w_data_o, 32'h600D_D00D);
      run_op(1, 1, 0, 5'd12, 1, 32'h10C, 32'd0, 3'b110, 2, 1, 32'h7777_1234, 0, 0);
      bubble();
      run_op(1, 0, 0, 5'd13, 1, 32'hFFFF_FFFF, 32'd0, 3'b000, 0, 1, 32'd0, 0, 0);
      bubble();

      // Bus timeout on a never-granted LW
      run_op(1, 1, 0, 5'd14, 1, 32'h200, 32'd0, 3'b010, 100000, 1, 32'd0, 0, 0);
      chk("to_berr", obs_berr, 1);
      chk("to_req_cycles", obs_req, TO + 1);
      chk("to_wb_ena", {31'd0, mem_wb_reg_w_ena_o}, 32'd0);
      bubble();

      // Reset while waiting for rvalid
      run_op(1, 1, 0, 5'd15, 1, 32'h400, 32'd0, 3'b010, 0, 5, 32'd0, 0, 1);
      bubble();
      run_op(1, 0, 0, 5'd16, 1, 32'h0000_4321, 32'd0, 3'b000, 0, 1, 32'd0, 0, 0);
      chk("post_rst_data", mem_wb_reg_w_data_o, 32'h0000_4321);
      bubble();

      chk_on = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
